// File: rtl/fifo_word_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_word_packer_pkg
// Purpose  : Shared defaults, FSM state encoding and lane-count width helper
//            for the read-side FIFO word packer.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_word_packer_pkg;

  localparam int c_WIDTH_DEF = 8;
  localparam int c_LANES_DEF = 4;

  typedef logic [1:0] state_t;

  localparam logic [1:0] c_ST_FILL  = 2'd0;
  localparam logic [1:0] c_ST_DRAIN = 2'd1;
  localparam logic [1:0] c_ST_OUT   = 2'd2;

  // Bits needed to hold a lane count from 0 up to and including lanes.
  function automatic int lane_cnt_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_word_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_word_packer_if
// Purpose  : FIFO read port plus packed-word valid/ready bus. The master
//            modport is the packer; the slave modport is its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_word_packer_if
  import fifo_word_packer_pkg::*;
#(
  parameter int WIDTH = c_WIDTH_DEF,
  parameter int LANES = c_LANES_DEF
);

  logic                          fifo_empty;
  logic                          read_en;
  logic [WIDTH-1:0]              fifo_data;
  logic                          flush;
  logic [WIDTH*LANES-1:0]        word_out;
  logic [lane_cnt_w(LANES)-1:0]  word_bytes;
  logic                          word_valid;
  logic                          word_ready;

  modport master (
    input  fifo_empty, fifo_data, flush, word_ready,
    output read_en, word_out, word_bytes, word_valid
  );

  modport slave (
    output fifo_empty, fifo_data, flush, word_ready,
    input  read_en, word_out, word_bytes, word_valid
  );

endinterface
`default_nettype wire

// File: rtl/fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_word_packer
// Purpose  : Pops bytes from the FIFO read port and packs LANES of them into
//            one wide word (lane 0 in the LSBs), presented on valid/ready.
//            A flush pulse emits a partially filled word, upper lanes zero.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_word_packer
  import fifo_word_packer_pkg::*;
#(
  parameter int WIDTH = c_WIDTH_DEF,
  parameter int LANES = c_LANES_DEF
) (
  input  logic                   clk_r,
  input  logic                   rst,
  fifo_word_packer_if.master     bus
);

  localparam int               c_CW   = lane_cnt_w(LANES);
  localparam logic [c_CW-1:0]  c_FULL = c_CW'(LANES);

  state_t                  r_state;
  logic [c_CW-1:0]         r_count;
  logic                    r_inflight;
  logic                    r_flush_pend;
  logic [WIDTH*LANES-1:0]  r_acc;
  logic [WIDTH*LANES-1:0]  r_word_out;
  logic [c_CW-1:0]         r_word_bytes;
  logic                    r_word_valid;

  logic [WIDTH*LANES-1:0]  w_acc_next;
  logic [c_CW-1:0]         w_cnt_next;
  logic                    w_room;
  logic                    w_flush_eff;
  logic                    w_read_en;

  // Lanes filled once the byte returning this cycle (if any) is captured.
  assign w_cnt_next = r_count + {{(c_CW-1){1'b0}}, r_inflight};
  assign w_room     = (w_cnt_next < c_FULL);

  // A flush only acts when a partial word exists and the word is not already
  // going to complete on its own.
  assign w_flush_eff = bus.flush && (r_state == c_ST_FILL) && w_room &&
                       ((r_count != '0) || r_inflight);

  // Pop request; an effective flush suppresses the read in its own cycle so
  // no byte arrives after the partial word has been closed.
  always_comb begin
    w_read_en = 1'b0;
    if (!rst) begin
      case (r_state)
        c_ST_FILL: w_read_en = !bus.fifo_empty && w_room && !r_flush_pend && !w_flush_eff;
        c_ST_OUT:  w_read_en = !bus.fifo_empty && bus.word_ready;
        default:   w_read_en = 1'b0;
      endcase
    end
  end

  // Accumulator image with the returning byte written into lane[count].
  always_comb begin
    w_acc_next = r_acc;
    if (r_inflight) begin
      for (int i = 0; i < LANES; i++) begin
        if (r_count == c_CW'(i)) begin
          w_acc_next[i*WIDTH +: WIDTH] = bus.fifo_data;
        end
      end
    end
  end

  // Packing FSM: fill lanes, optionally drain one in-flight byte, then hold
  // the word until it is accepted.
  always_ff @(posedge clk_r) begin
    if (rst) begin
      r_state      <= c_ST_FILL;
      r_count      <= '0;
      r_inflight   <= 1'b0;
      r_flush_pend <= 1'b0;
      r_acc        <= '0;
      r_word_out   <= '0;
      r_word_bytes <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_inflight <= w_read_en;
      case (r_state)
        c_ST_FILL: begin
          r_acc   <= w_acc_next;
          r_count <= w_cnt_next;
          if (w_cnt_next == c_FULL) begin
            r_state      <= c_ST_OUT;
            r_word_out   <= w_acc_next;
            r_word_bytes <= c_FULL;
            r_word_valid <= 1'b1;
          end else if (w_flush_eff) begin
            if (r_inflight) begin
              r_state      <= c_ST_DRAIN;
              r_flush_pend <= 1'b1;
            end else begin
              r_state      <= c_ST_OUT;
              r_word_out   <= r_acc;
              r_word_bytes <= r_count;
              r_word_valid <= 1'b1;
            end
          end
        end
        c_ST_DRAIN: begin
          r_acc        <= w_acc_next;
          r_count      <= w_cnt_next;
          r_state      <= c_ST_OUT;
          r_word_out   <= w_acc_next;
          r_word_bytes <= w_cnt_next;
          r_word_valid <= 1'b1;
          r_flush_pend <= 1'b0;
        end
        c_ST_OUT: begin
          if (bus.word_ready) begin
            r_state      <= c_ST_FILL;
            r_word_valid <= 1'b0;
            r_count      <= '0;
            r_acc        <= '0;
          end
        end
        default: r_state <= c_ST_FILL;
      endcase
    end
  end

  assign bus.read_en    = w_read_en;
  assign bus.word_out   = r_word_out;
  assign bus.word_bytes = r_word_bytes;
  assign bus.word_valid = r_word_valid;

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_word_packer
// Purpose  : Directed self-checking bench for fifo_word_packer with a small
//            byte FIFO model returning data the cycle after each pop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_word_packer;

  logic clk_r = 1'b0;
  logic rst   = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [0:63];
  int wp = 0;
  int rp = 0;

  fifo_word_packer_if #(.WIDTH(8), .LANES(4)) bus ();

  fifo_word_packer #(.WIDTH(8), .LANES(4)) dut (
    .clk_r (clk_r),
    .rst   (rst),
    .bus   (bus.master)
  );

  always #5 clk_r = ~clk_r;

  // FIFO model: empty reflects a pop at the same edge, data valid next cycle.
  assign bus.fifo_empty = (wp == rp);

  always @(posedge clk_r) begin
    if (bus.read_en) begin
      bus.fifo_data <= mem[rp];
      rp            <= rp + 1;
    end
  end

  task automatic step();
    @(posedge clk_r);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wp] = b;
    wp      = wp + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (bus.word_valid !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    n_checks++;
    assert (k < 20) else begin
      n_errors++;
      $error("FAIL %s: observed timeout expected word_valid within 20 cycles", tag);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush      = 1'b0;
    bus.word_ready = 1'b1;

    // Reset held with a non-empty FIFO
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (3) begin
      step();
      chk("rst_read_en",    32'(bus.read_en),    32'd0);
      chk("rst_word_valid", 32'(bus.word_valid), 32'd0);
      chk("rst_word_out",   bus.word_out,        32'd0);
    end

    // Full pack, four back-to-back reads
    rst = 1'b0;
    #1;
    chk("full_rd0", 32'(bus.read_en), 32'd1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("full_rd", 32'(bus.read_en), 32'd1);
    end
    step();
    chk("full_rd_stop", 32'(bus.read_en),    32'd0);
    chk("full_novalid", 32'(bus.word_valid), 32'd0);
    step();
    chk("full_valid", 32'(bus.word_valid), 32'd1);
    chk("full_word",  bus.word_out,        32'h44332211);
    chk("full_bytes", 32'(bus.word_bytes), 32'd4);
    step();
    chk("full_valid_1cyc", 32'(bus.word_valid), 32'd0);

    // Backpressure: word held for 5 cycles, no reads while FIFO non-empty
    bus.word_ready = 1'b0;
    push(8'h55); push(8'h66); push(8'h77); push(8'h88);
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    wait_valid("bp_wait");
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus.word_valid), 32'd1);
      chk("bp_word",  bus.word_out,        32'h88776655);
      chk("bp_rd",    32'(bus.read_en),    32'd0);
      if (i < 4) step();
    end
    bus.word_ready = 1'b1;
    #1;
    chk("bp_rd_release", 32'(bus.read_en), 32'd1);
    step();
    chk("bp_accepted", 32'(bus.word_valid), 32'd0);
    wait_valid("bp_next_wait");
    chk("bp_next_word",  bus.word_out,        32'h04030201);
    chk("bp_next_bytes", 32'(bus.word_bytes), 32'd4);
    step();
    chk("bp_next_acc", 32'(bus.word_valid), 32'd0);

    // Flush with two bytes captured and nothing in flight
    push(8'hAA); push(8'hBB);
    step(); step(); step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("fl_valid", 32'(bus.word_valid), 32'd1);
    chk("fl_word",  bus.word_out,        32'h0000BBAA);
    chk("fl_bytes", 32'(bus.word_bytes), 32'd2);
    step();
    chk("fl_acc", 32'(bus.word_valid), 32'd0);

    // Flush with an empty accumulator produces nothing
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    repeat (3) begin
      chk("fl0_novalid", 32'(bus.word_valid), 32'd0);
      step();
    end

    // Flush while the third byte is in flight
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    #1;
    chk("dr_rd0", 32'(bus.read_en), 32'd1);
    step(); step(); step();
    bus.flush = 1'b1;
    #1;
    chk("dr_no4th_rd", 32'(bus.read_en), 32'd0);
    step();
    bus.flush = 1'b0;
    chk("dr_novalid", 32'(bus.word_valid), 32'd0);
    chk("dr_rd_off",  32'(bus.read_en),    32'd0);
    step();
    chk("dr_valid", 32'(bus.word_valid), 32'd1);
    chk("dr_word",  bus.word_out,        32'h00C3C2C1);
    chk("dr_bytes", 32'(bus.word_bytes), 32'd3);
    step(); step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("dr_tail_word",  bus.word_out,        32'h000000C4);
    chk("dr_tail_bytes", 32'(bus.word_bytes), 32'd1);
    step();

    // Reset mid-fill discards the partial word
    push(8'hD1); push(8'hD2);
    step(); step(); step();
    rst = 1'b1;
    push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
    #1;
    chk("rm_rd_forced", 32'(bus.read_en), 32'd0);
    step();
    chk("rm_valid", 32'(bus.word_valid), 32'd0);
    chk("rm_word",  bus.word_out,        32'd0);
    chk("rm_bytes", 32'(bus.word_bytes), 32'd0);
    rst = 1'b0;
    wait_valid("rm_wait");
    chk("rm_new_word",  bus.word_out,        32'hE4E3E2E1);
    chk("rm_new_bytes", 32'(bus.word_bytes), 32'd4);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
